ann_mac_array: RTL and testbench

ANN_MAC_ARRAY -- requirements
Module: ann_mac_array

---
 rtl/ann_pkg.sv | 44 ++++
 rtl/ann_mac_lane.sv | 92 +++++++++
 rtl/ann_mac_array.sv | 96 +++++++++
 tb/tb_ann_mac_array.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// ann_pkg: shared definitions for the ANN MAC array.
//   state_t    - control FSM encoding used by ann_mac_array
//   wide_t     - wide signed working type for rounding/saturation math
//   roundShift - round-half-up then arithmetic shift right by frac bits
//   satClamp   - clamp a wide value into a w-bit signed range, flags clamping
package ann_pkg;

  localparam int MAX_W = 128;

  typedef logic signed [MAX_W-1:0] wide_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN1,
    S_DRAIN2,
    S_DONE
  } state_t;

  function automatic wide_t roundShift(input wide_t p, input int frac);
    wide_t half;
    half = wide_t'(1) <<< (frac - 1);
    return (p + half) >>> frac;
  endfunction

  function automatic wide_t satClamp(input wide_t v, input int w, output logic clamped);
    wide_t hi;
    wide_t lo;
    wide_t res;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    clamped = 1'b0;
    res = v;
    if (v > hi) begin
      res = hi;
      clamped = 1'b1;
    end else if (v < lo) begin
      res = lo;
      clamped = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ann_mac_lane.sv
// ann_mac_lane: one MAC channel.
//   clk, rst   - clock, synchronous active-high reset
//   accept     - a term is accepted this cycle (shared strobe)
//   first      - the accepted term starts a new dot product
//   vld_p1     - stage-1 product register holds an accepted term
//   done       - FSM in DONE: publish clamped result and clear accumulator
//   enable     - this channel takes part in the accepted term
//   data/weight- signed Q-format operands
//   result     - registered DATA_W-saturated result
//   sat        - sticky saturation flag for the current dot product
module ann_mac_lane
  import ann_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ACC_W  = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     accept,
  input  logic                     first,
  input  logic                     vld_p1,
  input  logic                     done,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] data,
  input  logic signed [DATA_W-1:0] weight,
  output logic signed [DATA_W-1:0] result,
  output logic                     sat
);

  logic signed [2*DATA_W-1:0] prod_p1;
  logic                       en_p1;
  logic signed [ACC_W-1:0]    acc_p2;

  wide_t rnd;
  wide_t sum;
  wide_t accSat;
  wide_t outSat;
  logic  accClamp;
  logic  outClamp;
  logic  unusedBits;

  // Stage 1: full-precision product register
  always_ff @(posedge clk) begin
    if (accept) begin
      prod_p1 <= (2*DATA_W)'(data) * (2*DATA_W)'(weight);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_p1 <= 1'b0;
    end else if (accept) begin
      en_p1 <= enable;
    end
  end

  // Stage 2: round the product and add into the saturating accumulator
  always_comb begin
    accClamp = 1'b0;
    outClamp = 1'b0;
    rnd      = roundShift(wide_t'(prod_p1), FRAC_W);
    sum      = wide_t'(acc_p2) + rnd;
    accSat   = satClamp(sum, ACC_W, accClamp);
    outSat   = satClamp(wide_t'(acc_p2), DATA_W, outClamp);
  end

  assign unusedBits = ^{accSat[MAX_W-1:ACC_W], outSat[MAX_W-1:DATA_W]};

  // The accumulator, result and sat all need a defined reset value, so
  // they are reset along with the control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p2 <= '0;
      result <= '0;
      sat    <= 1'b0;
    end else if (done) begin
      result <= outSat[DATA_W-1:0];
      sat    <= sat | outClamp;
      acc_p2 <= '0;
    end else if (vld_p1 && en_p1) begin
      acc_p2 <= accSat[ACC_W-1:0];
      if (accClamp) begin
        sat <= 1'b1;
      end
    end else if (first) begin
      // A new dot product starts: forget saturation of the previous one.
      sat <= 1'b0;
    end
  end

endmodule

// File: rtl/ann_mac_array.sv
// ann_mac_array: N_CH parallel signed fixed-point MAC channels sharing one
// control FSM (IDLE -> ACCUM -> DRAIN(2) -> DONE -> IDLE).
//   iClk, iReset - clock, synchronous active-high reset
//   iValid/oReady- term handshake, iLast marks the final term
//   iEnable      - per-channel accumulate mask
//   iData_in/iWeight - packed operands, channel k at [k*DATA_W +: DATA_W]
//   oData_out/oSat   - packed saturated results and per-channel sat flags
//   oValid       - one-cycle pulse when oData_out holds a new result
module ann_mac_array
  import ann_pkg::*;
#(
  parameter int N_CH   = 20,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ACC_W  = 48
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iValid,
  input  logic [N_CH-1:0]        iEnable,
  input  logic                   iLast,
  input  logic [N_CH*DATA_W-1:0] iData_in,
  input  logic [N_CH*DATA_W-1:0] iWeight,
  output logic                   oReady,
  output logic [N_CH*DATA_W-1:0] oData_out,
  output logic                   oValid,
  output logic [N_CH-1:0]        oSat
);

  state_t state;
  state_t stateNext;
  logic   accept;
  logic   first;
  logic   done;
  logic   vld_p1;

  assign oReady = (state == S_IDLE) || (state == S_ACCUM);
  assign accept = iValid && oReady;
  assign first  = accept && (state == S_IDLE);
  assign done   = (state == S_DONE);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state  <= S_IDLE;
      vld_p1 <= 1'b0;
      oValid <= 1'b0;
    end else begin
      state  <= stateNext;
      vld_p1 <= accept;
      oValid <= done;
    end
  end

  // The two DRAIN cycles let the last product pass stage 1 and stage 2
  // before DONE reads the accumulators.
  always_comb begin
    stateNext = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          stateNext = iLast ? S_DRAIN1 : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept && iLast) begin
          stateNext = S_DRAIN1;
        end
      end
      S_DRAIN1: stateNext = S_DRAIN2;
      S_DRAIN2: stateNext = S_DONE;
      S_DONE:   stateNext = S_IDLE;
      default:  stateNext = S_IDLE;
    endcase
  end

  for (genvar k = 0; k < N_CH; k++) begin : gLane
    ann_mac_lane #(
      .DATA_W(DATA_W),
      .FRAC_W(FRAC_W),
      .ACC_W (ACC_W)
    ) uLane (
      .clk   (iClk),
      .rst   (iReset),
      .accept(accept),
      .first (first),
      .vld_p1(vld_p1),
      .done  (done),
      .enable(iEnable[k]),
      .data  (iData_in[k*DATA_W +: DATA_W]),
      .weight(iWeight[k*DATA_W +: DATA_W]),
      .result(oData_out[k*DATA_W +: DATA_W]),
      .sat   (oSat[k])
    );
  end

endmodule

// File: tb/tb_ann_mac_array.sv
module tb_ann_mac_array;

  localparam int N  = 20;
  localparam int DW = 32;
  localparam int FW = 16;
  localparam int AW = 48;
  localparam longint AMAX = (64'sd1 <<< (AW - 1)) - 64'sd1;
  localparam longint AMIN = -(64'sd1 <<< (AW - 1));
  localparam longint DMAX = 64'sd2147483647;
  localparam longint DMIN = -64'sd2147483648;

  logic            iClk = 1'b0;
  logic            iReset = 1'b1;
  logic            iValid = 1'b0;
  logic [N-1:0]    iEnable = '0;
  logic            iLast = 1'b0;
  logic [N*DW-1:0] iData_in = '0;
  logic [N*DW-1:0] iWeight = '0;
  logic            oReady;
  logic [N*DW-1:0] oData_out;
  logic            oValid;
  logic [N-1:0]    oSat;

  always #5 iClk = ~iClk;

  ann_mac_array #(.N_CH(N), .DATA_W(DW), .FRAC_W(FW), .ACC_W(AW)) dut (
    .iClk     (iClk),
    .iReset   (iReset),
    .iValid   (iValid),
    .iEnable  (iEnable),
    .iLast    (iLast),
    .iData_in (iData_in),
    .iWeight  (iWeight),
    .oReady   (oReady),
    .oData_out(oData_out),
    .oValid   (oValid),
    .oSat     (oSat)
  );

  typedef struct {
    logic [N*DW-1:0] data;
    logic [N-1:0]    sat;
    int              cyc;
  } exp_t;

  exp_t         expQ[$];
  longint       macc[N];
  logic [N-1:0] msat;
  bit           inProd;
  int           compared = 0;
  int           mismatched = 0;
  int           cyc = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference model: dot product per channel with plain integer arithmetic.
  function automatic void modelReset();
    for (int k = 0; k < N; k++) macc[k] = 0;
    msat   = '0;
    inProd = 1'b0;
  endfunction

  function automatic void modelTerm(logic [N*DW-1:0] d, logic [N*DW-1:0] w, logic [N-1:0] en);
    longint p, r, s;
    if (!inProd) begin
      msat   = '0;
      inProd = 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      if (en[k]) begin
        p = longint'($signed(d[k*DW +: DW])) * longint'($signed(w[k*DW +: DW]));
        r = (p + (64'sd1 <<< (FW - 1))) >>> FW;
        s = macc[k] + r;
        if (s > AMAX) begin s = AMAX; msat[k] = 1'b1; end
        if (s < AMIN) begin s = AMIN; msat[k] = 1'b1; end
        macc[k] = s;
      end
    end
  endfunction

  function automatic void modelLast(int expCyc);
    exp_t   e;
    longint v;
    for (int k = 0; k < N; k++) begin
      v = macc[k];
      if (v > DMAX) begin v = DMAX; msat[k] = 1'b1; end
      if (v < DMIN) begin v = DMIN; msat[k] = 1'b1; end
      e.data[k*DW +: DW] = v[31:0];
      macc[k] = 0;
    end
    e.sat  = msat;
    e.cyc  = expCyc;
    inProd = 1'b0;
    expQ.push_back(e);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  logic [N*DW-1:0] lastOut = '0;
  bit              prevValid = 1'b0;

  always @(posedge iClk) begin
    exp_t e;
    #2;
    if (iReset) begin
      lastOut   = '0;
      prevValid = 1'b0;
    end else begin
      if (oValid) begin
        chk("oValid_one_cycle", 64'(prevValid), 64'd0);
        if (expQ.size() == 0) begin
          chk("unexpected_oValid", 64'd1, 64'd0);
        end else begin
          e = expQ.pop_front();
          chk("latency_cycle", 64'(cyc), 64'(e.cyc));
          for (int k = 0; k < N; k++)
            chk($sformatf("data_ch%0d", k), 64'(oData_out[k*DW +: DW]), 64'(e.data[k*DW +: DW]));
          chk("oSat", 64'(oSat), 64'(e.sat));
        end
        lastOut = oData_out;
      end else begin
        compared++;
        if (oData_out !== lastOut) begin
          mismatched++;
          $display("FAIL hold_oData_out: got %0h expected %0h", oData_out, lastOut);
        end
      end
      prevValid = oValid;
    end
  end

  // Driver tasks start and end just after a falling edge.
  task automatic term(input logic [N*DW-1:0] d, input logic [N*DW-1:0] w,
                      input logic [N-1:0] en, input bit last);
    bit accepted;
    int tries;
    int accCyc;
    accepted = 1'b0;
    tries    = 0;
    iData_in = d;
    iWeight  = w;
    iEnable  = en;
    iLast    = last;
    iValid   = 1'b1;
    while (!accepted) begin
      accCyc   = cyc;
      accepted = oReady;
      @(posedge iClk);
      if (accepted) begin
        modelTerm(d, w, en);
        if (last) modelLast(accCyc + 4);
      end
      @(negedge iClk);
      tries++;
      if (!accepted && tries > 20) begin
        chk("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    iValid = 1'b0;
    iLast  = 1'b0;
  endtask

  // After the final term: oReady low for three cycles; optionally offer a
  // term during DRAIN that must be ignored.
  task automatic gapCheck(input bit inject);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("oReady_gap%0d", i), 64'(oReady), (i == 3) ? 64'd1 : 64'd0);
      if (i < 3) begin
        if (inject && i == 0) begin
          iValid   = 1'b1;
          iLast    = 1'b0;
          iEnable  = '1;
          iData_in = {N{32'h0005_0000}};
          iWeight  = {N{32'h0003_0000}};
        end
        @(posedge iClk);
        @(negedge iClk);
        iValid = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] rword(bit full);
    logic [31:0] v;
    if (full) v = $urandom;
    else      v = 32'($urandom_range(0, 32'h0003FFFF)) - 32'h0001FFFF;
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iClk);
      @(negedge iClk);
    end
  endtask

  logic [N*DW-1:0] d, w;
  logic [N-1:0]    en;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bit full;
    modelReset();
    iReset = 1'b1;
    repeat (3) @(negedge iClk);
    iReset = 1'b0;
    @(negedge iClk);
    chk("reset_oReady", 64'(oReady), 64'd1);
    chk("reset_oValid", 64'(oValid), 64'd0);
    chk("reset_oData_out", 64'(oData_out[63:0]), 64'd0);
    chk("reset_oSat", 64'(oSat), 64'd0);

    // Single term 2.0 x 3.0 on channel 0
    d = '0; w = '0;
    d[31:0] = 32'h0002_0000;
    w[31:0] = 32'h0003_0000;
    term(d, w, '1, 1'b1);
    gapCheck(1'b0);
    chk("single_ch0", 64'(oData_out[31:0]), 64'h0006_0000);
    chk("single_sat", 64'(oSat), 64'd0);

    // Four back-to-back 1.0 x 0.5 terms on all channels
    for (int t = 0; t < 4; t++)
      term({N{32'h0001_0000}}, {N{32'h0000_8000}}, '1, t == 3);
    gapCheck(1'b0);
    for (int k = 0; k < N; k++)
      chk($sformatf("four_terms_ch%0d", k), 64'(oData_out[k*DW +: DW]), 64'h0002_0000);

    // Positive then negative overflow of the output range
    for (int t = 0; t < 2; t++)
      term({N{32'h7FFF_0000}}, {N{32'h7FFF_0000}}, '1, t == 1);
    gapCheck(1'b0);
    chk("ovf_pos_ch0", 64'(oData_out[31:0]), 64'h7FFF_FFFF);
    chk("ovf_pos_sat", 64'(oSat), 64'(20'hFFFFF));
    for (int t = 0; t < 2; t++)
      term({N{32'h8001_0000}}, {N{32'h7FFF_0000}}, '1, t == 1);
    gapCheck(1'b0);
    chk("ovf_neg_ch5", 64'(oData_out[5*DW +: DW]), 64'h8000_0000);
    chk("ovf_neg_sat", 64'(oSat), 64'(20'hFFFFF));

    // Accumulator-range saturation: (-1.0*2^15)^2 four times
    for (int t = 0; t < 4; t++)
      term({N{32'h8000_0000}}, {N{32'h8000_0000}}, '1, t == 3);
    gapCheck(1'b0);
    chk("acc_sat_ch0", 64'(oData_out[31:0]), 64'h7FFF_FFFF);
    chk("acc_sat_flags", 64'(oSat), 64'(20'hFFFFF));

    // Only channel 0 enabled
    d = '0;
    d[31:0]  = 32'h0001_0000;
    d[63:32] = 32'h0001_0000;
    term(d, {N{32'h0001_0000}}, 20'h00001, 1'b1);
    gapCheck(1'b0);
    chk("enable_ch0", 64'(oData_out[31:0]), 64'h0001_0000);
    chk("enable_ch1", 64'(oData_out[63:32]), 64'd0);

    // Term offered during DRAIN is ignored
    term({N{32'h0001_0000}}, {N{32'h0001_0000}}, '1, 1'b1);
    gapCheck(1'b1);
    term({N{32'h0002_0000}}, {N{32'h0002_0000}}, '1, 1'b1);
    gapCheck(1'b0);
    chk("after_drain_ch3", 64'(oData_out[3*DW +: DW]), 64'h0004_0000);

    // Reset pulsed in DRAIN discards the in-flight product
    term({N{32'h0003_0000}}, {N{32'h0003_0000}}, '1, 1'b1);
    iReset = 1'b1;
    expQ.delete();
    modelReset();
    @(posedge iClk);
    @(negedge iClk);
    iReset = 1'b0;
    chk("rst_drain_oData_out", 64'(oData_out[63:0]), 64'd0);
    chk("rst_drain_oReady", 64'(oReady), 64'd1);
    chk("rst_drain_oValid", 64'(oValid), 64'd0);
    idle(6);
    d = '0; w = '0;
    d[31:0] = 32'h0001_0000;
    w[31:0] = 32'h0001_0000;
    term(d, w, '1, 1'b1);
    gapCheck(1'b0);
    chk("post_reset_ch0", 64'(oData_out[31:0]), 64'h0001_0000);

    // Randomized dot products
    for (int p = 0; p < 40; p++) begin
      len  = $urandom_range(1, 5);
      full = ($urandom_range(0, 3) == 0);
      en   = ($urandom_range(0, 1) == 0) ? '1 : N'($urandom);
      for (int t = 0; t < len; t++) begin
        for (int k = 0; k < N; k++) begin
          d[k*DW +: DW] = rword(full);
          w[k*DW +: DW] = rword(full);
        end
        term(d, w, en, t == len - 1);
        idle($urandom_range(0, 2));
      end
      if ($urandom_range(0, 1) == 0) idle(4);
    end

    idle(10);
    chk("scoreboard_empty", 64'(expQ.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
